// File: rtl/spimemio_cache_pkg.sv
// Shared constants and address-split helpers for the spimemio read cache.
package spimemio_cache_pkg;

    // Controller states
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RESP = 2'd1;
    localparam logic [1:0] FILL = 2'd2;

    // Byte-offset width within a line: word select plus the 2 byte bits
    function automatic int unsigned calc_off_w(input int unsigned line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int unsigned calc_idx_w(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                               input int unsigned num_lines,
                                               input int unsigned line_words);
        return addr_w - calc_idx_w(num_lines) - calc_off_w(line_words);
    endfunction

endpackage

// File: rtl/spimemio_cache_store.sv
// Line data storage: flop array with one write port and one asynchronous read port.
module spimemio_cache_store
    import spimemio_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_WORDS = 4,
    localparam int unsigned IDX_W     = calc_idx_w(NUM_LINES),
    localparam int unsigned WORD_W    = calc_off_w(LINE_WORDS) - 2
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_w_idx,
    input  logic [WORD_W-1:0] i_w_word,
    input  logic [31:0]       i_w_data,
    input  logic [IDX_W-1:0]  i_r_idx,
    input  logic [WORD_W-1:0] i_r_word,
    output logic [31:0]       o_r_data
);

    logic [31:0] r_mem [NUM_LINES*LINE_WORDS];

    // Data array is deliberately not reset; valid bits guard its contents
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[{i_w_idx, i_w_word}] <= i_w_data;
        end
    end

    assign o_r_data = r_mem[{i_r_idx, i_r_word}];

endmodule

// File: rtl/spimemio_cache.sv
// Direct-mapped read cache in front of spimemio; whole-line sequential fills
// keep the flash in its continuous-read burst. cache_en=0 is a pure bypass.
module spimemio_cache
    import spimemio_cache_pkg::*;
#(
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic              i_mem_valid,
    output logic              o_mem_ready,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [31:0]       o_mem_rdata,
    output logic              o_flash_valid,
    input  logic              i_flash_ready,
    output logic [ADDR_W-1:0] o_flash_addr,
    input  logic [31:0]       i_flash_rdata,
    input  logic              i_cache_en,
    input  logic              i_cache_inv
);

    localparam int unsigned OFF_W  = calc_off_w(LINE_WORDS);
    localparam int unsigned IDX_W  = calc_idx_w(NUM_LINES);
    localparam int unsigned TAG_W  = calc_tag_w(ADDR_W, NUM_LINES, LINE_WORDS);
    localparam int unsigned WORD_W = OFF_W - 2;
    localparam int unsigned BASE_W = ADDR_W - OFF_W;

    logic [1:0]           r_state,  w_state_d;
    logic [NUM_LINES-1:0] r_valid,  w_valid_d;
    logic                 r_poison, w_poison_d;
    logic [BASE_W-1:0]    r_base,   w_base_d;
    logic [WORD_W-1:0]    r_k,      w_k_d;
    logic [31:0]          r_rdata,  w_rdata_d;
    logic [TAG_W-1:0]     r_tag [NUM_LINES];

    logic [IDX_W-1:0]  w_idx;
    logic [WORD_W-1:0] w_word;
    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_fill_idx;
    logic [TAG_W-1:0]  w_fill_tag;
    logic              w_hit;
    logic              w_fill_ack;
    logic              w_fill_last;
    logic [31:0]       w_store_rdata;
    logic              w_unused_addr;

    assign w_idx         = i_mem_addr[OFF_W +: IDX_W];
    assign w_word        = i_mem_addr[2 +: WORD_W];
    assign w_tag         = i_mem_addr[ADDR_W-1 -: TAG_W];
    assign w_fill_idx    = r_base[IDX_W-1:0];
    assign w_fill_tag    = r_base[BASE_W-1 -: TAG_W];
    assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill_ack    = (r_state == FILL) && i_flash_ready;
    assign w_fill_last   = w_fill_ack && (r_k == WORD_W'(LINE_WORDS - 1));
    assign w_unused_addr = ^i_mem_addr[1:0];

    spimemio_cache_store #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_store (
        .i_clk    (i_clk),
        .i_we     (w_fill_ack),
        .i_w_idx  (w_fill_idx),
        .i_w_word (r_k),
        .i_w_data (i_flash_rdata),
        .i_r_idx  (w_idx),
        .i_r_word (w_word),
        .o_r_data (w_store_rdata)
    );

    // Next-state: lookup in IDLE, one-cycle response, sequential line fill
    always_comb begin
        w_state_d  = r_state;
        w_valid_d  = r_valid;
        w_poison_d = r_poison;
        w_base_d   = r_base;
        w_k_d      = r_k;
        w_rdata_d  = r_rdata;
        if (!i_cache_en) begin
            w_state_d = IDLE;
            w_valid_d = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_mem_valid) begin
                        if (w_hit) begin
                            w_rdata_d = w_store_rdata;
                            w_state_d = RESP;
                        end else begin
                            w_base_d   = i_mem_addr[ADDR_W-1:OFF_W];
                            w_k_d      = '0;
                            w_poison_d = 1'b0;
                            w_state_d  = FILL;
                        end
                    end
                end
                RESP: w_state_d = IDLE;
                FILL: begin
                    if (i_flash_ready) begin
                        w_k_d = r_k + 1'b1;
                        if (w_fill_last) begin
                            w_state_d = IDLE;
                            if (!r_poison) begin
                                w_valid_d[w_fill_idx] = 1'b1;
                            end
                        end
                    end
                end
                default: w_state_d = IDLE;
            endcase
            // Invalidate overrides any line completed this cycle
            if (i_cache_inv) begin
                w_valid_d = '0;
                if (r_state == FILL) begin
                    w_poison_d = 1'b1;
                end
            end
        end
    end

    // Controller state, valid bits and response data
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state  <= IDLE;
            r_valid  <= '0;
            r_poison <= 1'b0;
            r_base   <= '0;
            r_k      <= '0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_d;
            r_valid  <= w_valid_d;
            r_poison <= w_poison_d;
            r_base   <= w_base_d;
            r_k      <= w_k_d;
            r_rdata  <= w_rdata_d;
        end
    end

    // Tag array is not reset; written once the last word of a line lands
    always_ff @(posedge i_clk) begin
        if (w_fill_last) begin
            r_tag[w_fill_idx] <= w_fill_tag;
        end
    end

    // Cache mode drives registered outputs; bypass is a straight wire-through
    always_comb begin
        if (i_cache_en) begin
            o_flash_valid = (r_state == FILL);
            o_flash_addr  = {r_base, r_k, 2'b00};
            o_mem_ready   = (r_state == RESP);
            o_mem_rdata   = r_rdata;
        end else begin
            o_flash_valid = i_mem_valid;
            o_flash_addr  = {i_mem_addr[ADDR_W-1:2], 2'b00};
            o_mem_ready   = i_flash_ready;
            o_mem_rdata   = i_flash_rdata;
        end
    end

endmodule

// File: tb/tb_spimemio_cache.sv
// Directed bench for spimemio_cache with a spimemio-like flash model.
module tb_spimemio_cache;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic        mem_ready;
    logic [23:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        flash_valid;
    logic        flash_ready;
    logic [23:0] flash_addr;
    logic [31:0] flash_rdata;
    logic        cache_en;
    logic        cache_inv;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_ack_cyc = 0;
    int          fv_cycles = 0;
    logic [23:0] fa_log[$];
    logic [1:0]  fcnt = 2'd0;
    logic [23:0] snap_fa;
    logic        snap_fr;
    logic [31:0] d;
    int          lat;
    int          rc;
    int          fv_before;

    spimemio_cache #(
        .ADDR_W     (24),
        .NUM_LINES  (16),
        .LINE_WORDS (4)
    ) dut (
        .i_clk         (clk),
        .i_resetn      (resetn),
        .i_mem_valid   (mem_valid),
        .o_mem_ready   (mem_ready),
        .i_mem_addr    (mem_addr),
        .o_mem_rdata   (mem_rdata),
        .o_flash_valid (flash_valid),
        .i_flash_ready (flash_ready),
        .o_flash_addr  (flash_addr),
        .i_flash_rdata (flash_rdata),
        .i_cache_en    (cache_en),
        .i_cache_inv   (cache_inv)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_word(input logic [23:0] a);
        return {8'hA5, a};
    endfunction

    // Flash answers in the third cycle an address is presented
    assign flash_ready = flash_valid && (fcnt == 2'd2);
    assign flash_rdata = model_word(flash_addr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!flash_valid || flash_ready) fcnt <= 2'd0;
        else fcnt <= fcnt + 2'd1;
    end

    // Log accepted flash addresses mid-cycle
    always @(negedge clk) begin
        if (flash_valid) fv_cycles <= fv_cycles + 1;
        if (flash_valid && flash_ready) begin
            fa_log.push_back(flash_addr);
            last_ack_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input string tag, input logic [23:0] a,
                           output logic [31:0] data, output int latency, output int rdy_cyc);
        bit ok;
        int start;
        ok = 1'b0;
        @(negedge clk);
        mem_addr  = a;
        mem_valid = 1'b1;
        start     = cyc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_ready_seen"}, 32'(ok), 32'd1);
        data    = mem_rdata;
        latency = cyc - start;
        rdy_cyc = cyc;
        snap_fa = flash_addr;
        snap_fr = flash_ready;
        @(posedge clk);
        #1 mem_valid = 1'b0;
    endtask

    task automatic check_fill(input string tag, input logic [23:0] base, input int reps);
        check({tag, "_fill_len"}, 32'(fa_log.size()), 32'(4 * reps));
        for (int i = 0; i < 4 * reps; i++) begin
            if (i < fa_log.size())
                check($sformatf("%s_fill%0d", tag, i), 32'(fa_log[i]),
                      32'(base + 24'(4 * (i % 4))));
        end
        fa_log.delete();
    endtask

    initial begin
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        cache_en  = 1'b1;
        cache_inv = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_flash_valid", 32'(flash_valid), 32'd0);
        check("rst_flash_addr", 32'(flash_addr), 32'd0);
        resetn = 1'b1;

        // 1: cold miss fills the whole line sequentially
        do_read("t1", 24'h000010, d, lat, rc);
        check("t1_data", d, model_word(24'h000010));
        check("t1_ready_gap", 32'(rc - last_ack_cyc), 32'd2);
        check_fill("t1", 24'h000010, 1);

        // 2: hit in the same line, no flash traffic
        fv_before = fv_cycles;
        do_read("t2", 24'h000018, d, lat, rc);
        check("t2_data", d, model_word(24'h000018));
        check("t2_latency", 32'(lat), 32'd1);
        check("t2_no_flash", 32'(fv_cycles - fv_before), 32'd0);
        check("t2_log_empty", 32'(fa_log.size()), 32'd0);

        // 3: conflicting tag on index 1 evicts, then the old line refills
        do_read("t3a", 24'h000110, d, lat, rc);
        check("t3a_data", d, model_word(24'h000110));
        check_fill("t3a", 24'h000110, 1);
        do_read("t3b", 24'h000010, d, lat, rc);
        check("t3b_data", d, model_word(24'h000010));
        check_fill("t3b", 24'h000010, 1);

        // 4: invalidate during the second fill word poisons the line
        fork
            do_read("t4", 24'h000024, d, lat, rc);
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (fa_log.size() >= 1) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("t4_first_word_seen", 32'(seen), 32'd1);
                @(negedge clk);
                cache_inv = 1'b1;
                @(negedge clk);
                cache_inv = 1'b0;
            end
        join
        check("t4_data", d, model_word(24'h000024));
        check_fill("t4", 24'h000020, 2);

        // 5: bypass passes straight through, and clears the cache
        @(negedge clk);
        cache_en = 1'b0;
        do_read("t5", 24'h000204, d, lat, rc);
        check("t5_data", d, model_word(24'h000204));
        check("t5_flash_addr", 32'(snap_fa), 32'h000204);
        check("t5_flash_ready", 32'(snap_fr), 32'd1);
        check("t5_log_len", 32'(fa_log.size()), 32'd1);
        fa_log.delete();
        @(negedge clk);
        cache_en = 1'b1;
        do_read("t5b", 24'h000028, d, lat, rc);
        check("t5b_data", d, model_word(24'h000028));
        check_fill("t5b", 24'h000020, 1);
        do_read("t5c", 24'h000010, d, lat, rc);
        check("t5c_data", d, model_word(24'h000010));
        check_fill("t5c", 24'h000010, 1);

        // 6: asynchronous reset in the middle of a fill
        @(negedge clk);
        mem_addr  = 24'h000030;
        mem_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_in_fill", 32'(flash_valid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_flash_valid", 32'(flash_valid), 32'd0);
        check("t6_rst_mem_ready", 32'(mem_ready), 32'd0);
        check("t6_rst_mem_rdata", mem_rdata, 32'd0);
        mem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        fa_log.delete();
        do_read("t6", 24'h000010, d, lat, rc);
        check("t6_data", d, model_word(24'h000010));
        check_fill("t6", 24'h000010, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
